vx_scoreboard_mp: RTL and testbench

Parametrised successor scoreboard for the issue stage. It tracks outstanding register writes per warp with saturating in-flight counters instead of single busy bits, and accepts NUM_WB_PORTS writeback channels per cycle. It sits between the instruction buffer and dispatch, gating issue on RAW/WAW hazards. It also provides a wrapping stall counter, a stall watchdog and an underflow error flag.

---
 rtl/vx_sboard_pkg.sv | 38 +++
 rtl/vx_scoreboard_bank.sv | 64 ++++++
 rtl/vx_scoreboard_mp.sv | 153 +++++++++++++++
 tb/tb_vx_scoreboard_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_sboard_pkg.sv
// Shared widths, writeback-match counting and the saturating counter update for the scoreboard.
package vx_sboard_pkg;

    localparam int NUM_WARPS_DEF   = 4;
    localparam int NUM_REGS_DEF    = 64;
    localparam int MAX_PENDING_DEF = 3;

    // Writeback ports are normalised into fixed-size vectors so the helpers stay width-agnostic.
    localparam int MAX_WB = 8;
    localparam int ID_W   = 16;

    localparam int WID_W = (NUM_WARPS_DEF > 1) ? $clog2(NUM_WARPS_DEF) : 1;
    localparam int REG_W = $clog2(NUM_REGS_DEF);
    localparam int CNT_W = $clog2(MAX_PENDING_DEF + 1);

    typedef logic [MAX_WB-1:0][ID_W-1:0] id_vec_t;

    function automatic int port_hits(input logic [MAX_WB-1:0] rel, input id_vec_t wids,
                                     input id_vec_t rds, input int wid, input int rg);
        int n;
        n = 0;
        for (int p = 0; p < MAX_WB; p++) begin
            if (rel[p] && (int'(wids[p]) == wid) && (int'(rds[p]) == rg)) n++;
        end
        return n;
    endfunction

    function automatic int sat_update(input int cnt, input int inc, input int dec,
                                      input int max_v, output logic uf);
        int n;
        n  = cnt + inc - dec;
        uf = (n < 0);
        if (n < 0)     n = 0;
        if (n > max_v) n = max_v;
        return n;
    endfunction

endpackage

// File: rtl/vx_scoreboard_bank.sv
// One warp's per-register in-flight write counters.
// Latency: counters and any_pending update on the clock edge; read ports are combinational from state.
module vx_scoreboard_bank
    import vx_sboard_pkg::*;
#(
    parameter int NUM_REGS    = 64,
    parameter int MAX_PENDING = 3,
    parameter int RW          = 6,
    parameter int CW          = 2,
    parameter int DW          = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc_vld,
    input  logic [RW-1:0]                inc_rd,
    input  logic [NUM_REGS-1:0][DW-1:0]  dec_cnt,
    input  logic [RW-1:0]                rs1,
    input  logic [RW-1:0]                rs2,
    input  logic [RW-1:0]                rs3,
    input  logic [RW-1:0]                rd,
    output logic [CW-1:0]                rs1_cnt,
    output logic [CW-1:0]                rs2_cnt,
    output logic [CW-1:0]                rs3_cnt,
    output logic [CW-1:0]                rd_cnt,
    output logic                         any_pending,
    output logic                         uf
);

    logic [NUM_REGS-1:0][CW-1:0] cnt_q, cnt_d;
    logic                        any_pending_q, any_pending_d;
    logic                        uf_r;

    // Register 0 is never tracked, so its counter is pinned at zero.
    always_comb begin
        cnt_d = cnt_q;
        uf    = 1'b0;
        uf_r  = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = CW'(sat_update(int'(cnt_q[r]),
                                      (inc_vld && (int'(inc_rd) == r)) ? 1 : 0,
                                      int'(dec_cnt[r]), MAX_PENDING, uf_r));
            uf = uf | uf_r;
        end
        cnt_d[0]      = '0;
        any_pending_d = |cnt_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            any_pending_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            any_pending_q <= any_pending_d;
        end
    end

    assign rs1_cnt     = cnt_q[rs1];
    assign rs2_cnt     = cnt_q[rs2];
    assign rs3_cnt     = cnt_q[rs3];
    assign rd_cnt      = cnt_q[rd];
    assign any_pending = any_pending_q;

endmodule

// File: rtl/vx_scoreboard_mp.sv
// Multi-port issue scoreboard: per-warp/register in-flight counters gate issue on RAW/WAW hazards.
// Latency: ibuf_ready is combinational from registered counters; releases become visible next cycle.
// Backpressure: ibuf_ready drops on hazard; stalls are counted and watched by a sticky watchdog.
module vx_scoreboard_mp
    import vx_sboard_pkg::*;
#(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_REGS     = 64,
    parameter int NUM_WB_PORTS = 2,
    parameter int MAX_PENDING  = 3,
    parameter int ALLOW_WAW    = 0,
    parameter int CTR_W        = 44,
    parameter int TIMEOUT      = 4096,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RW = $clog2(NUM_REGS),
    localparam int CW = $clog2(MAX_PENDING + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ibuf_valid,
    output logic                         ibuf_ready,
    input  logic [WW-1:0]                ibuf_wid,
    input  logic                         ibuf_wb,
    input  logic [RW-1:0]                ibuf_rd,
    input  logic [RW-1:0]                ibuf_rs1,
    input  logic [RW-1:0]                ibuf_rs2,
    input  logic [RW-1:0]                ibuf_rs3,
    input  logic [NUM_WB_PORTS-1:0]      wb_valid,
    input  logic [NUM_WB_PORTS*WW-1:0]   wb_wid,
    input  logic [NUM_WB_PORTS*RW-1:0]   wb_rd,
    input  logic [NUM_WB_PORTS-1:0]      wb_eop,
    output logic [NUM_WARPS-1:0]         warp_pending,
    output logic [CTR_W-1:0]             stall_cycles,
    output logic                         timeout_err,
    output logic [WW-1:0]                timeout_wid,
    output logic                         underflow_err
);

    localparam int DW = $clog2(NUM_WB_PORTS + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [MAX_WB-1:0]              rel_v;
    id_vec_t                        wid_v, rd_v;
    logic [NUM_WARPS-1:0][CW-1:0]   rs1_cnt, rs2_cnt, rs3_cnt, rd_cnt;
    logic [NUM_WARPS-1:0]           bank_uf;
    logic [CW-1:0]                  rs1_c, rs2_c, rs3_c, rd_c;
    logic                           fire, stall, hit;

    logic [CTR_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [TW-1:0]    run_q, run_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WW-1:0]    timeout_wid_q, timeout_wid_d;
    logic             underflow_err_q, underflow_err_d;

    // NUM_WB_PORTS must not exceed MAX_WB; only eop beats release a write.
    always_comb begin
        rel_v = '0;
        wid_v = '0;
        rd_v  = '0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            rel_v[p] = wb_valid[p] & wb_eop[p];
            wid_v[p] = ID_W'(wb_wid[p*WW +: WW]);
            rd_v[p]  = ID_W'(wb_rd[p*RW +: RW]);
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
        logic [NUM_REGS-1:0][DW-1:0] dec_cnt;

        always_comb begin
            dec_cnt = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                dec_cnt[r] = DW'(port_hits(rel_v, wid_v, rd_v, w, r));
            end
        end

        vx_scoreboard_bank #(
            .NUM_REGS    (NUM_REGS),
            .MAX_PENDING (MAX_PENDING),
            .RW          (RW),
            .CW          (CW),
            .DW          (DW)
        ) u_bank (
            .clk         (clk),
            .reset       (reset),
            .inc_vld     (fire && ibuf_wb && (ibuf_wid == WW'(w))),
            .inc_rd      (ibuf_rd),
            .dec_cnt     (dec_cnt),
            .rs1         (ibuf_rs1),
            .rs2         (ibuf_rs2),
            .rs3         (ibuf_rs3),
            .rd          (ibuf_rd),
            .rs1_cnt     (rs1_cnt[w]),
            .rs2_cnt     (rs2_cnt[w]),
            .rs3_cnt     (rs3_cnt[w]),
            .rd_cnt      (rd_cnt[w]),
            .any_pending (warp_pending[w]),
            .uf          (bank_uf[w])
        );
    end

    always_comb begin
        rs1_c = '0;
        rs2_c = '0;
        rs3_c = '0;
        rd_c  = '0;
        if (int'(ibuf_wid) < NUM_WARPS) begin
            rs1_c = rs1_cnt[ibuf_wid];
            rs2_c = rs2_cnt[ibuf_wid];
            rs3_c = rs3_cnt[ibuf_wid];
            rd_c  = rd_cnt[ibuf_wid];
        end
        ibuf_ready = !((rs1_c != '0) || (rs2_c != '0) || (rs3_c != '0) ||
                       (ibuf_wb && (int'(rd_c) == MAX_PENDING)) ||
                       (ibuf_wb && (ALLOW_WAW == 0) && (rd_c != '0)));
        fire  = ibuf_valid && ibuf_ready;
        stall = ibuf_valid && !ibuf_ready;
    end

    // The run counter saturates at TIMEOUT so a long stall cannot wrap it back below the threshold.
    always_comb begin
        stall_cycles_d  = stall_cycles_q + CTR_W'(stall);
        run_d           = run_q;
        if (!ibuf_valid || fire)        run_d = '0;
        else if (run_q != TW'(TIMEOUT)) run_d = run_q + 1'b1;
        hit             = (TIMEOUT != 0) && stall && (run_d == TW'(TIMEOUT)) && !timeout_err_q;
        timeout_err_d   = timeout_err_q | hit;
        timeout_wid_d   = hit ? ibuf_wid : timeout_wid_q;
        underflow_err_d = underflow_err_q | (|bank_uf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q  <= '0;
            run_q           <= '0;
            timeout_err_q   <= 1'b0;
            timeout_wid_q   <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            run_q           <= run_d;
            timeout_err_q   <= timeout_err_d;
            timeout_wid_q   <= timeout_wid_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign timeout_err   = timeout_err_q;
    assign timeout_wid   = timeout_wid_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_vx_scoreboard_mp.sv
// Directed bench for vx_scoreboard_mp: issue, dual release, saturation, watchdog, underflow, x0, reset.
module tb_vx_scoreboard_mp;
    import vx_sboard_pkg::*;

    localparam int NP = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ibuf_valid, ibuf_ready, ibuf_wb;
    logic [WID_W-1:0]      ibuf_wid;
    logic [REG_W-1:0]      ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic [NP-1:0]         wb_valid, wb_eop;
    logic [NP*WID_W-1:0]   wb_wid;
    logic [NP*REG_W-1:0]   wb_rd;
    logic [3:0]            warp_pending;
    logic [43:0]           stall_cycles;
    logic                  timeout_err, underflow_err;
    logic [WID_W-1:0]      timeout_wid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vx_scoreboard_mp #(
        .NUM_WARPS(4), .NUM_REGS(64), .NUM_WB_PORTS(NP), .MAX_PENDING(3),
        .ALLOW_WAW(1), .CTR_W(44), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_wid(ibuf_wid),
        .ibuf_wb(ibuf_wb), .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2),
        .ibuf_rs3(ibuf_rs3), .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
        .wb_eop(wb_eop), .warp_pending(warp_pending), .stall_cycles(stall_cycles),
        .timeout_err(timeout_err), .timeout_wid(timeout_wid), .underflow_err(underflow_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int wid, input logic wb, input int rd,
                         input int s1, input int s2, input int s3);
        ibuf_valid = v;
        ibuf_wid   = WID_W'(wid);
        ibuf_wb    = wb;
        ibuf_rd    = REG_W'(rd);
        ibuf_rs1   = REG_W'(s1);
        ibuf_rs2   = REG_W'(s2);
        ibuf_rs3   = REG_W'(s3);
    endtask

    task automatic wb_set(input int p, input logic eop, input int wid, input int rd);
        wb_valid[p]                 = 1'b1;
        wb_eop[p]                   = eop;
        wb_wid[p*WID_W +: WID_W]    = WID_W'(wid);
        wb_rd[p*REG_W +: REG_W]     = REG_W'(rd);
    endtask

    task automatic wb_clear;
        wb_valid = '0;
        wb_eop   = '0;
        wb_wid   = '0;
        wb_rd    = '0;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        wb_clear();
        #12;
        chk("rst_ready", 64'(ibuf_ready), 64'd1);
        chk("rst_pend", 64'(warp_pending), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);
        chk("rst_twid", 64'(timeout_wid), 64'd0);
        chk("rst_uf", 64'(underflow_err), 64'd0);
        reset = 1'b1;
        tick();

        // Issue to w1 r5, RAW in w1 only, non-eop beat does not release, release has no bypass.
        drive(1, 1, 1, 5, 0, 0, 0);
        #1 chk("t1_issue_rdy", 64'(ibuf_ready), 64'd1);
        tick();
        drive(1, 1, 0, 0, 5, 0, 0);
        #1 chk("t1_raw_w1", 64'(ibuf_ready), 64'd0);
        chk("t1_pend", 64'(warp_pending), 64'b0010);
        drive(1, 0, 0, 0, 5, 0, 0);
        #1 chk("t1_w0_free", 64'(ibuf_ready), 64'd1);
        drive(0, 1, 0, 0, 5, 0, 0);
        wb_set(0, 1'b0, 1, 5);
        tick();
        wb_clear();
        #1 chk("t1_noeop", 64'(ibuf_ready), 64'd0);
        wb_set(0, 1'b1, 1, 5);
        #1 chk("t1_nobypass", 64'(ibuf_ready), 64'd0);
        tick();
        wb_clear();
        #1 chk("t1_released", 64'(ibuf_ready), 64'd1);
        chk("t1_pend_clr", 64'(warp_pending), 64'd0);

        // Two writes in flight to w0 r7, both ports release in one cycle.
        drive(1, 0, 1, 7, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 7, 0, 0);
        #1 chk("t2_busy", 64'(ibuf_ready), 64'd0);
        chk("t2_pend", 64'(warp_pending), 64'b0001);
        wb_set(0, 1'b1, 0, 7);
        wb_set(1, 1'b1, 0, 7);
        tick();
        wb_clear();
        #1 chk("t2_dual_rel", 64'(ibuf_ready), 64'd1);
        chk("t2_uf", 64'(underflow_err), 64'd0);

        // Issue and release on w2 r3 in the same cycle keeps the count at 1.
        drive(1, 2, 1, 3, 0, 0, 0);
        tick();
        wb_set(1, 1'b1, 2, 3);
        #1 chk("t3_rdy", 64'(ibuf_ready), 64'd1);
        tick();
        wb_clear();
        drive(0, 2, 0, 0, 3, 0, 0);
        #1 chk("t3_held", 64'(ibuf_ready), 64'd0);
        chk("t3_uf", 64'(underflow_err), 64'd0);
        chk("t3_pend", 64'(warp_pending), 64'b0100);
        wb_set(0, 1'b1, 2, 3);
        tick();
        wb_clear();
        #1 chk("t3_free", 64'(ibuf_ready), 64'd1);

        // Saturation at MAX_PENDING=3 on w0 r9, then three stall cycles.
        drive(1, 0, 1, 9, 0, 0, 0);
        repeat (3) tick();
        #1 chk("t4_sat", 64'(ibuf_ready), 64'd0);
        repeat (3) tick();
        chk("t4_stall", 64'(stall_cycles), 64'd3);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_nowb", 64'(ibuf_ready), 64'd1);
        drive(0, 0, 0, 0, 9, 0, 0);
        wb_set(0, 1'b1, 0, 9);
        repeat (2) tick();
        #1 chk("t4_one_left", 64'(ibuf_ready), 64'd0);
        tick();
        wb_clear();
        #1 chk("t4_drained", 64'(ibuf_ready), 64'd1);
        chk("t4_pend", 64'(warp_pending), 64'd0);

        // Watchdog: RAW stall on w3 for TIMEOUT=8 cycles.
        drive(1, 3, 1, 10, 0, 0, 0);
        tick();
        drive(1, 3, 0, 0, 10, 0, 0);
        #1 chk("t5_raw", 64'(ibuf_ready), 64'd0);
        repeat (7) tick();
        chk("t5_pre_to", 64'(timeout_err), 64'd0);
        tick();
        chk("t5_to", 64'(timeout_err), 64'd1);
        chk("t5_wid", 64'(timeout_wid), 64'd3);
        drive(0, 3, 0, 0, 10, 0, 0);
        wb_set(0, 1'b1, 3, 10);
        tick();
        wb_clear();
        #1 chk("t5_rel_rdy", 64'(ibuf_ready), 64'd1);
        chk("t5_sticky", 64'(timeout_err), 64'd1);
        chk("t5_stall", 64'(stall_cycles), 64'd11);

        // x0 is ignored; a release to a zero counter flags underflow.
        drive(1, 1, 1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1 chk("t6_x0_pend", 64'(warp_pending), 64'd0);
        wb_set(0, 1'b1, 1, 0);
        tick();
        wb_clear();
        #1 chk("t6_x0_uf", 64'(underflow_err), 64'd0);
        wb_set(1, 1'b1, 1, 4);
        tick();
        wb_clear();
        #1 chk("t6_uf", 64'(underflow_err), 64'd1);

        // Asynchronous reset mid-operation, then a stale release.
        drive(1, 0, 1, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        #1 chk("t7_busy", 64'(ibuf_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("t7_rdy", 64'(ibuf_ready), 64'd1);
        chk("t7_pend", 64'(warp_pending), 64'd0);
        chk("t7_stall", 64'(stall_cycles), 64'd0);
        chk("t7_terr", 64'(timeout_err), 64'd0);
        chk("t7_twid", 64'(timeout_wid), 64'd0);
        chk("t7_uf", 64'(underflow_err), 64'd0);
        #1 reset = 1'b1;
        wb_set(0, 1'b1, 0, 1);
        tick();
        wb_clear();
        #1 chk("t7_stale_uf", 64'(underflow_err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
